de_scoreboard: RTL and testbench

DE_SCOREBOARD -- requirements
Module: de_scoreboard

---
 rtl/de_scoreboard.sv | 125 ++++++++++++
 tb/tb_de_scoreboard.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de_scoreboard.sv
// Decode-stage register/CSR scoreboard: tracks pending writers per entry,
// raises a combinational hazard stall, and keeps stall/error statistics.
module de_scoreboard #(
  parameter int unsigned REGWORDS  = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned CSRREGNUM = 16,
  parameter int unsigned CSRNOBITS = 4,
  parameter int unsigned DBITS     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REGNOBITS-1:0] issue_rs1,
  input  logic [REGNOBITS-1:0] issue_rs2,
  input  logic                 issue_rs1_read,
  input  logic                 issue_rs2_read,
  input  logic                 issue_wr_reg,
  input  logic [REGNOBITS-1:0] issue_rd,
  input  logic                 issue_rd_csr,
  input  logic                 issue_wr_csr,
  input  logic [CSRNOBITS-1:0] issue_csrno,
  input  logic                 kill_valid,
  input  logic                 kill_wr_reg,
  input  logic [REGNOBITS-1:0] kill_rd,
  input  logic                 kill_wr_csr,
  input  logic [CSRNOBITS-1:0] kill_csrno,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_wregno,
  input  logic                 wb_wr_csr,
  input  logic [CSRNOBITS-1:0] wb_wcsrno,
  output logic                 stall_DE,
  output logic                 issue_accept,
  output logic [DBITS-1:0]     stall_cycles,
  output logic                 sb_error
);

  logic [1:0]       reg_cnt_q [REGWORDS];
  logic [1:0]       reg_cnt_d [REGWORDS];
  logic [1:0]       reg_eff   [REGWORDS];
  logic [1:0]       csr_cnt_q [CSRREGNUM];
  logic [1:0]       csr_cnt_d [CSRREGNUM];
  logic [1:0]       csr_eff   [CSRREGNUM];
  logic [DBITS-1:0] stall_cycles_q;
  logic             sb_error_q;
  logic             err_set;
  logic [2:0]       res;

  // Returns {underflow, next count}: +inc, -wb, -kill, clamped to 0..3.
  function automatic logic [2:0] net_cnt(input logic [1:0] cnt, input logic inc,
                                         input logic dw, input logic dk);
    logic [2:0] up, dec, rem;
    up  = {1'b0, cnt} + {2'b00, inc};
    dec = {2'b00, dw} + {2'b00, dk};
    if (up < dec) return 3'b100;
    rem = up - dec;
    return {1'b0, (rem > 3'd3) ? 2'd3 : rem[1:0]};
  endfunction

  // A same-cycle WB is visible to DE because the register file writes on negedge.
  always_comb begin
    for (int unsigned i = 0; i < REGWORDS; i++) begin
      reg_eff[i] = reg_cnt_q[i];
      if (wb_wr_reg && wb_wregno == REGNOBITS'(i) && reg_cnt_q[i] != 2'd0)
        reg_eff[i] = reg_cnt_q[i] - 2'd1;
    end
    for (int unsigned i = 0; i < CSRREGNUM; i++) begin
      csr_eff[i] = csr_cnt_q[i];
      if (wb_wr_csr && wb_wcsrno == CSRNOBITS'(i) && csr_cnt_q[i] != 2'd0)
        csr_eff[i] = csr_cnt_q[i] - 2'd1;
    end
  end

  always_comb begin
    stall_DE = 1'b0;
    if (!reset && issue_valid) begin
      if (issue_rs1_read && reg_eff[issue_rs1] != 2'd0) stall_DE = 1'b1;
      if (issue_rs2_read && reg_eff[issue_rs2] != 2'd0) stall_DE = 1'b1;
      if (issue_wr_reg && issue_rd != '0 && reg_eff[issue_rd] == 2'd3) stall_DE = 1'b1;
      if ((issue_rd_csr || issue_wr_csr) && csr_eff[issue_csrno] != 2'd0) stall_DE = 1'b1;
    end
  end

  assign issue_accept = !reset && issue_valid && !stall_DE;

  always_comb begin
    err_set      = 1'b0;
    res          = '0;
    reg_cnt_d[0] = '0;
    for (int unsigned i = 1; i < REGWORDS; i++) begin
      res = net_cnt(reg_cnt_q[i],
                    issue_accept && issue_wr_reg && issue_rd == REGNOBITS'(i),
                    wb_wr_reg && wb_wregno == REGNOBITS'(i),
                    kill_valid && kill_wr_reg && kill_rd == REGNOBITS'(i));
      reg_cnt_d[i] = res[1:0];
      err_set      = err_set | res[2];
    end
    for (int unsigned i = 0; i < CSRREGNUM; i++) begin
      res = net_cnt(csr_cnt_q[i],
                    issue_accept && issue_wr_csr && issue_csrno == CSRNOBITS'(i),
                    wb_wr_csr && wb_wcsrno == CSRNOBITS'(i),
                    kill_valid && kill_wr_csr && kill_csrno == CSRNOBITS'(i));
      csr_cnt_d[i] = res[1:0];
      err_set      = err_set | res[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REGWORDS; i++) reg_cnt_q[i] <= '0;
      for (int unsigned i = 0; i < CSRREGNUM; i++) csr_cnt_q[i] <= '0;
      stall_cycles_q <= '0;
      sb_error_q     <= 1'b0;
    end else begin
      reg_cnt_q  <= reg_cnt_d;
      csr_cnt_q  <= csr_cnt_d;
      sb_error_q <= sb_error_q | err_set;
      if (stall_DE && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign sb_error     = sb_error_q;

endmodule

// File: tb/tb_de_scoreboard.sv
// Self-checking bench for de_scoreboard: directed vector table, CSR/kill,
// error, saturation and async-reset sequences, plus random traffic vs a model.
module tb_de_scoreboard;

  localparam int SCMAX = 1023;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_rs1_read, issue_rs2_read, issue_wr_reg;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       issue_rd_csr, issue_wr_csr;
  logic [3:0] issue_csrno;
  logic       kill_valid, kill_wr_reg, kill_wr_csr;
  logic [4:0] kill_rd;
  logic [3:0] kill_csrno;
  logic       wb_wr_reg, wb_wr_csr;
  logic [4:0] wb_wregno;
  logic [3:0] wb_wcsrno;
  logic       stall_DE, issue_accept, sb_error;
  logic [9:0] stall_cycles;

  de_scoreboard #(.DBITS(10)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_read(issue_rs1_read), .issue_rs2_read(issue_rs2_read),
    .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
    .issue_rd_csr(issue_rd_csr), .issue_wr_csr(issue_wr_csr), .issue_csrno(issue_csrno),
    .kill_valid(kill_valid), .kill_wr_reg(kill_wr_reg), .kill_rd(kill_rd),
    .kill_wr_csr(kill_wr_csr), .kill_csrno(kill_csrno),
    .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .wb_wr_csr(wb_wr_csr), .wb_wcsrno(wb_wcsrno),
    .stall_DE(stall_DE), .issue_accept(issue_accept),
    .stall_cycles(stall_cycles), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit [4:0] rs1; bit r1; bit [4:0] rs2; bit r2; bit wr; bit [4:0] rd;
    bit rcsr; bit wcsr; bit [3:0] csr;
    bit kv; bit kwr; bit [4:0] krd; bit kwc; bit [3:0] kcsr;
    bit wbw; bit [4:0] wbno; bit wbc; bit [3:0] wbcno;
  } in_t;

  typedef struct {
    bit v; bit [4:0] rs1; bit r1; bit wr; bit [4:0] rd; bit wbw; bit [4:0] wbno;
    bit es; bit ea;
  } vec_t;

  int npass = 0;
  int ntotal = 0;
  int rcnt[32];
  int ccnt[16];
  int sc;
  bit err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else npass++;
  endtask

  function automatic in_t idle();
    in_t x = '{default: '0};
    return x;
  endfunction

  task automatic drive(input in_t x);
    issue_valid = x.v; issue_rs1 = x.rs1; issue_rs1_read = x.r1;
    issue_rs2 = x.rs2; issue_rs2_read = x.r2; issue_wr_reg = x.wr; issue_rd = x.rd;
    issue_rd_csr = x.rcsr; issue_wr_csr = x.wcsr; issue_csrno = x.csr;
    kill_valid = x.kv; kill_wr_reg = x.kwr; kill_rd = x.krd;
    kill_wr_csr = x.kwc; kill_csrno = x.kcsr;
    wb_wr_reg = x.wbw; wb_wregno = x.wbno; wb_wr_csr = x.wbc; wb_wcsrno = x.wbcno;
  endtask

  function automatic void model_reset();
    foreach (rcnt[i]) rcnt[i] = 0;
    foreach (ccnt[i]) ccnt[i] = 0;
    sc = 0;
    err = 0;
  endfunction

  // Pending writers visible to DE: a same-cycle WB already counts as retired.
  function automatic int reff(int r, in_t x);
    return rcnt[r] - ((x.wbw && int'(x.wbno) == r && rcnt[r] > 0) ? 1 : 0);
  endfunction

  function automatic int ceff(int c, in_t x);
    return ccnt[c] - ((x.wbc && int'(x.wbcno) == c && ccnt[c] > 0) ? 1 : 0);
  endfunction

  function automatic bit model_stall(in_t x);
    if (!x.v) return 0;
    if (x.r1 && reff(int'(x.rs1), x) > 0) return 1;
    if (x.r2 && reff(int'(x.rs2), x) > 0) return 1;
    if (x.wr && x.rd != 0 && reff(int'(x.rd), x) == 3) return 1;
    if ((x.rcsr || x.wcsr) && ceff(int'(x.csr), x) > 0) return 1;
    return 0;
  endfunction

  function automatic void model_update(in_t x, bit acc, bit st);
    int v;
    for (int r = 1; r < 32; r++) begin
      v = rcnt[r] + ((acc && x.wr && int'(x.rd) == r) ? 1 : 0)
                  - ((x.wbw && int'(x.wbno) == r) ? 1 : 0)
                  - ((x.kv && x.kwr && int'(x.krd) == r) ? 1 : 0);
      if (v < 0) begin err = 1; v = 0; end
      rcnt[r] = (v > 3) ? 3 : v;
    end
    for (int c = 0; c < 16; c++) begin
      v = ccnt[c] + ((acc && x.wcsr && int'(x.csr) == c) ? 1 : 0)
                  - ((x.wbc && int'(x.wbcno) == c) ? 1 : 0)
                  - ((x.kv && x.kwc && int'(x.kcsr) == c) ? 1 : 0);
      if (v < 0) begin err = 1; v = 0; end
      ccnt[c] = (v > 3) ? 3 : v;
    end
    if (st && sc < SCMAX) sc++;
  endfunction

  task automatic eval(input in_t x, input string nm);
    bit es, ea;
    es = model_stall(x);
    ea = x.v && !es;
    chk({nm, " stall_DE"}, stall_DE, es);
    chk({nm, " issue_accept"}, issue_accept, ea);
    chk({nm, " stall_cycles"}, stall_cycles, sc);
    chk({nm, " sb_error"}, sb_error, err);
    model_update(x, ea, es);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input in_t x, input string nm);
    drive(x);
    #3;
    eval(x, nm);
    tick();
  endtask

  vec_t tbl[$];
  in_t  x;
  int   q[$];

  initial begin
    // Dependency, write-depth and x0 sequences; expectations derived by hand.
    tbl.push_back('{1, 1, 1, 1, 5, 0, 0, 0, 1});
    tbl.push_back('{1, 5, 1, 1, 6, 0, 0, 1, 0});
    tbl.push_back('{1, 5, 1, 1, 6, 0, 0, 1, 0});
    tbl.push_back('{1, 5, 1, 1, 6, 1, 5, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 6, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 7, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 7, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 7, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 7, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 1, 7, 1, 7, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 7, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 7, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 7, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 7, 0, 0});

    model_reset();
    reset = 1'b1;
    x = idle();
    x.v = 1; x.wr = 1; x.rd = 5'd2;
    drive(x);
    #3;
    chk("reset stall_DE", stall_DE, 0);
    chk("reset issue_accept", issue_accept, 0);
    chk("reset stall_cycles", stall_cycles, 0);
    chk("reset sb_error", sb_error, 0);
    drive(idle());
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      x = idle();
      x.v = tbl[i].v; x.rs1 = tbl[i].rs1; x.r1 = tbl[i].r1; x.wr = tbl[i].wr;
      x.rd = tbl[i].rd; x.wbw = tbl[i].wbw; x.wbno = tbl[i].wbno;
      drive(x);
      #3;
      chk($sformatf("vec%0d stall", i), stall_DE, tbl[i].es);
      chk($sformatf("vec%0d accept", i), issue_accept, tbl[i].ea);
      eval(x, $sformatf("vec%0d", i));
      tick();
    end
    chk("vec stall_cycles total", stall_cycles, 4);

    // CSR write squashed by kill, then CSR read accepted.
    x = idle(); x.v = 1; x.wcsr = 1; x.csr = 4'd2;
    step(x, "csrw2");
    x = idle(); x.v = 1; x.rcsr = 1; x.csr = 4'd2; x.kv = 1; x.kwc = 1; x.kcsr = 4'd2;
    drive(x); #3;
    chk("csr kill-cycle stall", stall_DE, 1);
    eval(x, "csr kill"); tick();
    x = idle(); x.v = 1; x.rcsr = 1; x.csr = 4'd2;
    drive(x); #3;
    chk("csrr2 after kill accept", issue_accept, 1);
    eval(x, "csrr2"); tick();
    x = idle(); x.v = 1; x.wcsr = 1; x.csr = 4'd3;
    step(x, "csrw3");
    x = idle(); x.v = 1; x.rcsr = 1; x.csr = 4'd3; x.wbc = 1; x.wbcno = 4'd3;
    drive(x); #3;
    chk("csrr3 same-cycle wb accept", issue_accept, 1);
    eval(x, "csrr3 wb"); tick();

    // Random traffic on a narrow register/CSR window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      x = idle();
      x.v = ($urandom_range(0, 3) != 0);
      x.rs1 = 5'($urandom_range(0, 7)); x.r1 = 1'($urandom_range(0, 1));
      x.rs2 = 5'($urandom_range(0, 7)); x.r2 = 1'($urandom_range(0, 1));
      x.wr = 1'($urandom_range(0, 1)); x.rd = 5'($urandom_range(0, 7));
      x.rcsr = ($urandom_range(0, 5) == 0); x.wcsr = ($urandom_range(0, 4) == 0);
      x.csr = 4'($urandom_range(0, 3));
      q.delete();
      for (int r = 1; r < 8; r++) if (rcnt[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        x.wbw = 1; x.wbno = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        x.wbw = 1; x.wbno = 5'd0;
      end
      q.delete();
      for (int r = 1; r < 8; r++) if (reff(r, x) > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 3) == 0) begin
        x.kv = 1; x.kwr = 1; x.krd = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      q.delete();
      for (int c = 0; c < 4; c++) if (ccnt[c] > 0) q.push_back(c);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        x.wbc = 1; x.wbcno = 4'(q[$urandom_range(0, q.size() - 1)]);
      end
      q.delete();
      for (int c = 0; c < 4; c++) if (ceff(c, x) > 0) q.push_back(c);
      if (q.size() > 0 && $urandom_range(0, 5) == 0) begin
        x.kv = 1; x.kwc = 1; x.kcsr = 4'(q[$urandom_range(0, q.size() - 1)]);
      end
      step(x, $sformatf("rnd%0d", n));
    end

    // Release of x9 with nothing pending: sticky error.
    chk("sb_error before bad wb", sb_error, 0);
    x = idle(); x.wbw = 1; x.wbno = 5'd9;
    step(x, "bad wb x9");
    chk("sb_error set", sb_error, 1);
    for (int n = 0; n < 3; n++) step(idle(), "idle after err");
    chk("sb_error sticky", sb_error, 1);

    // Hold a RAW stall on x9 until the 10-bit counter saturates.
    x = idle(); x.v = 1; x.wr = 1; x.rd = 5'd9;
    step(x, "wr x9");
    x = idle(); x.v = 1; x.rs1 = 5'd9; x.r1 = 1;
    for (int n = 0; n < 1100; n++) step(x, "sat");
    chk("stall_cycles saturated", stall_cycles, 10'h3FF);
    step(x, "sat hold");
    chk("stall_cycles no wrap", stall_cycles, 10'h3FF);
    x = idle(); x.wbw = 1; x.wbno = 5'd9;
    step(x, "wb x9");

    // Asynchronous reset mid-cycle while stalled.
    x = idle(); x.v = 1; x.wr = 1; x.rd = 5'd4; x.rs1 = 5'd4; x.r1 = 1;
    step(x, "wr x4");
    x = idle(); x.v = 1; x.rs1 = 5'd4; x.r1 = 1;
    drive(x); #3;
    chk("pre-reset stall", stall_DE, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset stall_DE", stall_DE, 0);
    chk("async reset issue_accept", issue_accept, 0);
    chk("async reset stall_cycles", stall_cycles, 0);
    chk("async reset sb_error", sb_error, 0);
    model_reset();
    x = idle(); x.v = 1; x.rs1 = 5'd4; x.r1 = 1; x.wr = 1; x.rd = 5'd4;
    drive(x);
    #1;
    reset = 1'b0;
    #1;
    chk("post-reset accept", issue_accept, 1);
    eval(x, "post-reset");
    tick();
    x = idle(); x.v = 1; x.rs1 = 5'd4; x.r1 = 1;
    drive(x); #3;
    chk("post-reset dependent stall", stall_DE, 1);
    eval(x, "post-reset dep"); tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
